// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder with IDLE/RUN/DONE control; one full-adder slice reused per cycle, LSB first.
// Define SERIAL_ADD_CIN_EN to add a cin port that seeds the initial carry (otherwise the initial carry is 0).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADD_CIN_EN
    input  logic             cin,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, part_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             carry_init;
    logic             last_bit;
    logic             ha1_s, ha1_c, ha2_s, ha2_c, fa_c;

`ifdef SERIAL_ADD_CIN_EN
    assign carry_init = cin;
`else
    assign carry_init = 1'b0;
`endif

    // Full adder built from two half-adder stages and an OR
    assign ha1_s = a_sh_reg[0] ^ b_sh_reg[0];
    assign ha1_c = a_sh_reg[0] & b_sh_reg[0];
    assign ha2_s = ha1_s ^ carry_reg;
    assign ha2_c = ha1_s & carry_reg;
    assign fa_c  = ha1_c | ha2_c;

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == RUN);
        done = (state_reg == DONE);
    end

    // Sum bits enter the partial register at the MSB so the word is aligned after WIDTH shifts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            part_reg  <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        part_reg  <= '0;
                        cnt_reg   <= '0;
                        carry_reg <= carry_init;
                    end
                end
                RUN: begin
                    a_sh_reg  <= a_sh_reg >> 1;
                    b_sh_reg  <= b_sh_reg >> 1;
                    part_reg  <= {ha2_s, part_reg[WIDTH-1:1]};
                    carry_reg <= fa_c;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        s  <= {ha2_s, part_reg[WIDTH-1:1]};
                        co <= fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): vector table plus hand-written multi-cycle sequences.
// Works with or without SERIAL_ADD_CIN_EN defined.
module tb_serial_add_ctrl;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
`ifdef SERIAL_ADD_CIN_EN
    logic       cin;
`endif
    logic [7:0] a, b;
    logic       busy, done;
    logic [7:0] s;
    logic       co;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SERIAL_ADD_CIN_EN
        .cin   (cin),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full operation: start at E0, operands scrambled afterwards, result checked at E8 and held.
    task automatic do_op(input vec_t v, input string name);
        logic [7:0] prev_s;
        logic       prev_co;
        int         busy_low, done_seen, out_moved;
        prev_s    = s;
        prev_co   = co;
        busy_low  = 0;
        done_seen = 0;
        out_moved = 0;
        a = v.a;
        b = v.b;
`ifdef SERIAL_ADD_CIN_EN
        cin = v.cin;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        a = ~v.a;
        b = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            if (k == 2) begin
                a = 8'h00;
                b = 8'h00;
            end
            if (busy !== 1'b1) busy_low++;
            if (done !== 1'b0) done_seen++;
            if (s !== prev_s || co !== prev_co) out_moved++;
        end
        check({name, " busy E1..E8"}, 32'(busy_low), 32'd0);
        check({name, " no early done"}, 32'(done_seen), 32'd0);
        check({name, " no partial result"}, 32'(out_moved), 32'd0);
        tick();
        check({name, " done pulse"}, {31'd0, done}, 32'd1);
        check({name, " busy after E8"}, {31'd0, busy}, 32'd0);
        check({name, " s"}, {24'd0, s}, {24'd0, v.s});
        check({name, " co"}, {31'd0, co}, {31'd0, v.co});
        $display("op %s: a=%02h b=%02h -> s=%02h co=%0b (exp %02h %0b)", name, v.a, v.b, s, co, v.s, v.co);
        tick();
        check({name, " done one cycle"}, {31'd0, done}, 32'd0);
        repeat (5) tick();
        check({name, " s held"}, {24'd0, s}, {24'd0, v.s});
        check({name, " co held"}, {31'd0, co}, {31'd0, v.co});
    endtask

    vec_t vecs[8];
    int   acc[$];
    int   dones;
    logic prev_busy;

    initial begin
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[4] = '{8'hC3, 8'h5A, 1'b0, 8'h1D, 1'b1};
        vecs[5] = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
`ifdef SERIAL_ADD_CIN_EN
        vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
`else
        vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'hFF, 1'b0};
`endif

        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
`ifdef SERIAL_ADD_CIN_EN
        cin   = 1'b0;
`endif
        repeat (2) tick();
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset s", {24'd0, s}, 32'd0);
        check("reset co", {31'd0, co}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // start held high: acceptances every WIDTH+2 edges
        a = 8'h01;
        b = 8'h01;
`ifdef SERIAL_ADD_CIN_EN
        cin = 1'b0;
`endif
        start = 1'b1;
        dones = 0;
        for (int e = 0; e < 30; e++) begin
            prev_busy = busy;
            tick();
            if (!prev_busy && busy) acc.push_back(e);
            if (done) dones++;
        end
        start = 1'b0;
        check("hold accept count", 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            check("hold accept 1", 32'(acc[0]), 32'd0);
            check("hold accept 2", 32'(acc[1]), 32'd10);
            check("hold accept 3", 32'(acc[2]), 32'd20);
        end
        check("hold done count", 32'(dones), 32'd3);
        check("hold s", {24'd0, s}, 32'h02);
        $display("op hold-start: acceptances=%0d dones=%0d s=%02h", acc.size(), dones, s);
        tick();

        // reset at E4 aborts the operation
        a = 8'h55;
        b = 8'hAA;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort s", {24'd0, s}, 32'd0);
        check("abort co", {31'd0, co}, 32'd0);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            tick();
            if (done) dones++;
        end
        check("abort no done", 32'(dones), 32'd0);
        $display("op abort: a=55 b=AA reset at E4, later dones=%0d", dones);

        // reset beats start; start accepted at first edge with rst_n=1
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        check("reset priority busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("accept after reset", {31'd0, busy}, 32'd1);
        start = 1'b0;
        repeat (8) tick();
        check("post-reset done", {31'd0, done}, 32'd1);
        check("post-reset s", {24'd0, s}, 32'hFF);
        $display("op post-reset: a=55 b=AA -> s=%02h co=%0b", s, co);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH SHALL have default 8 and set the operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on rising clk.
REQ-004 start  input  1  SHALL request an addition; it is sampled only in IDLE.
REQ-005 a  input  WIDTH  SHALL be operand A, captured at the accepting edge.
REQ-006 b  input  WIDTH  SHALL be operand B, captured at the accepting edge.
REQ-007 busy  output  1  SHALL be high while in RUN.
REQ-008 done  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-009 s  output  WIDTH  SHALL be the registered sum of the last completed addition.
REQ-010 co  output  1  SHALL be the registered carry-out of the last completed addition.

Function
REQ-011 The block SHALL have three states: IDLE, RUN and DONE.
REQ-012 The datapath SHALL be one bit-slice made of two half-adder stages plus an OR, i.e. a full adder, reused once per cycle.
REQ-013 IDLE with start=1 at edge E0 SHALL capture a and b into shift registers, clear the bit counter, load the carry flop with its initial value, and enter RUN.
REQ-014 Each RUN edge SHALL combine operand bit[cnt] (LSB first) with the carry flop, shift the sum bit into a partial register, update the carry, and increment cnt.
REQ-015 The edge processing bit WIDTH-1 (edge E_WIDTH) SHALL load s and co from the partial register and the carry, and enter DONE.
REQ-016 Latency: done SHALL be high exactly in the cycle after E_WIDTH; DONE SHALL return to IDLE on the next edge unconditionally.
REQ-017 start SHALL be ignored in RUN and DONE; the earliest next acceptance is the edge E_WIDTH+2.
REQ-018 Changes on a or b after E0 SHALL NOT affect the result in progress.
REQ-019 s and co SHALL hold their values from REQ-015 until the next completion or reset; they SHALL NOT show partial results during RUN.
REQ-020 Arithmetic SHALL be unsigned modulo 2^WIDTH, and co SHALL be the bit-WIDTH carry.
REQ-021 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap inside a single operation.

Reset
REQ-022 rst_n=0 at any edge SHALL force IDLE, busy=0, done=0, s=0, co=0, clear the counter, carry and shift registers, and take priority over start.
REQ-023 A reset during RUN or DONE SHALL abort the operation with no done pulse; start is accepted at the first edge with rst_n=1.

Configuration
REQ-024 Macro SERIAL_ADD_CIN_EN defined: a port cin (input, 1 bit, carry-in) SHALL exist and SHALL be captured at E0 as the initial carry.
REQ-025 Macro SERIAL_ADD_CIN_EN undefined: the cin port SHALL be absent and the initial carry SHALL be 0.

Verification (WIDTH=8)
REQ-026 a=8'h0F, b=8'h01, start at E0 -> busy high for E1..E8; done is high only in the cycle after E8; s=8'h10; co=0.
REQ-027 a=8'hFF, b=8'h01 -> s=8'h00, co=1; s and co are still unchanged 5 cycles later.
REQ-028 start held high for 30 cycles with a=8'h01, b=8'h01 -> acceptances at E0, E10 and E20; exactly one done pulse per operation; s=8'h02.
REQ-029 a=8'h55, b=8'hAA started, then rst_n=0 at E4 -> after E4 busy=0, done=0, s=0, co=0; no done pulse follows.
REQ-030 a and b changed to 8'h00 at E2 after starting with 8'h80+8'h80 -> s=8'h00, co=1.
REQ-031 With SERIAL_ADD_CIN_EN: a=8'hFF, b=8'h00, cin=1 -> s=8'h00, co=1. Without it: the same a and b give s=8'hFF, co=0.
